// File: rtl/qkv_projection_engine_if.sv
// Stream, memory-read and result signals of the QKV projection engine.
// The engine connects through the slave modport; the surrounding system through master.
interface qkv_projection_engine_if #(
  parameter int unsigned NUM_HEADS  = 6,
  parameter int unsigned HEAD_DIM   = 64,
  parameter int unsigned MAX_TOKENS = 128,
  parameter int unsigned BUS_WIDTH  = 512
);
  localparam int unsigned HEAD_W = (NUM_HEADS > 1) ? $clog2(NUM_HEADS) : 1;
  localparam int unsigned DIM_W  = (HEAD_DIM > 1) ? $clog2(HEAD_DIM) : 1;
  localparam int unsigned TOK_W  = (MAX_TOKENS > 1) ? $clog2(MAX_TOKENS) : 1;

  logic                 start;
  logic [TOK_W-1:0]     token_id;
  logic [31:0]          weight_base_addr;

  logic                 in_valid;
  logic                 in_ready;
  logic [31:0]          in_data;

  logic                 mem_rd_en;
  logic [31:0]          mem_rd_addr;
  logic [BUS_WIDTH-1:0] mem_rd_data;
  logic                 mem_rd_valid;

  logic                 out_valid;
  logic                 out_ready;
  logic [31:0]          out_data;
  logic [1:0]           out_sel;
  logic [HEAD_W-1:0]    out_head;
  logic [DIM_W-1:0]     out_dim;
  logic [TOK_W-1:0]     out_token;
  logic                 done;

  modport slave (
    input  start, token_id, weight_base_addr,
    input  in_valid, in_data,
    input  mem_rd_data, mem_rd_valid,
    input  out_ready,
    output in_ready,
    output mem_rd_en, mem_rd_addr,
    output out_valid, out_data, out_sel, out_head, out_dim, out_token,
    output done
  );

  modport master (
    output start, token_id, weight_base_addr,
    output in_valid, in_data,
    output mem_rd_data, mem_rd_valid,
    output out_ready,
    input  in_ready,
    input  mem_rd_en, mem_rd_addr,
    input  out_valid, out_data, out_sel, out_head, out_dim, out_token,
    input  done
  );
endinterface

// File: rtl/qkv_projection_engine.sv
// Projects one token embedding through the packed [Wq;Wk;Wv] matrix, one weight beat
// at a time, and emits one rounded, saturated Q16.16 result per matrix row.
module qkv_projection_engine #(
  parameter int unsigned EMBEDDING_DIM = 384,
  parameter int unsigned NUM_HEADS     = 6,
  parameter int unsigned HEAD_DIM      = 64,
  parameter int unsigned MAX_TOKENS    = 128,
  parameter int unsigned BUS_WIDTH     = 512
) (
  input  logic                  clk,
  input  logic                  rst_n,
  qkv_projection_engine_if.slave bus
);
  localparam int unsigned WPB    = BUS_WIDTH / 32;
  localparam int unsigned BEATS  = EMBEDDING_DIM / WPB;
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned WORD_W = (WPB > 1) ? $clog2(WPB) : 1;
  localparam int unsigned HEAD_W = (NUM_HEADS > 1) ? $clog2(NUM_HEADS) : 1;
  localparam int unsigned DIM_W  = (HEAD_DIM > 1) ? $clog2(HEAD_DIM) : 1;
  localparam int unsigned TOK_W  = (MAX_TOKENS > 1) ? $clog2(MAX_TOKENS) : 1;

  localparam logic [31:0]        BEAT_BYTES = 32'(BUS_WIDTH / 8);
  localparam logic signed [63:0] RND_HALF   = 64'sh0000_0000_0000_8000;
  localparam logic signed [63:0] SAT_MAX    = 64'sh0000_0000_7FFF_FFFF;
  localparam logic signed [63:0] SAT_MIN    = 64'shFFFF_FFFF_8000_0000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_REQ,
    S_WAIT,
    S_EMIT
  } state_t;

  state_t state_q, state_d;

  // Embedding buffer, organised by beat so each weight beat lines up with one slot row
  logic [31:0]        buf_mem [BEATS][WPB];
  logic [BEAT_W-1:0]  ld_beat_q;
  logic [WORD_W-1:0]  ld_word_q;

  logic [BEAT_W-1:0]  beat_q;
  logic [1:0]         sel_q;
  logic [HEAD_W-1:0]  head_q;
  logic [DIM_W-1:0]   dim_q;
  logic signed [63:0] acc_q;
  logic [31:0]        next_addr_q;
  logic [31:0]        held_addr_q;
  logic [TOK_W-1:0]   token_q;
  logic               done_q;

  logic               load_last;
  logic               beat_last;
  logic               dim_last;
  logic               head_last;
  logic               row_last;

  logic signed [63:0] beat_sum;
  logic signed [63:0] prod_a;
  logic signed [63:0] prod_b;
  logic signed [63:0] rounded;
  logic signed [63:0] shifted;
  logic [31:0]        result;

  assign load_last = (ld_beat_q == BEAT_W'(BEATS - 1)) && (ld_word_q == WORD_W'(WPB - 1));
  assign beat_last = (beat_q == BEAT_W'(BEATS - 1));
  assign dim_last  = (dim_q == DIM_W'(HEAD_DIM - 1));
  assign head_last = (head_q == HEAD_W'(NUM_HEADS - 1));
  assign row_last  = (sel_q == 2'd2) && head_last && dim_last;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (bus.start)                   state_d = S_LOAD;
      S_LOAD: if (bus.in_valid && load_last)   state_d = S_REQ;
      S_REQ:                                   state_d = S_WAIT;
      S_WAIT: if (bus.mem_rd_valid)            state_d = beat_last ? S_EMIT : S_REQ;
      S_EMIT: if (bus.out_ready)               state_d = row_last ? S_IDLE : S_REQ;
      default:                                 state_d = S_IDLE;
    endcase
  end

  // The request address is only presented live during REQ; otherwise the last one is held
  always_comb begin
    bus.in_ready    = (state_q == S_LOAD);
    bus.mem_rd_en   = (state_q == S_REQ);
    bus.mem_rd_addr = (state_q == S_REQ) ? next_addr_q : held_addr_q;
    bus.out_valid   = (state_q == S_EMIT);
    bus.out_data    = (state_q == S_EMIT) ? result : '0;
    bus.out_sel     = sel_q;
    bus.out_head    = head_q;
    bus.out_dim     = dim_q;
    bus.out_token   = token_q;
    bus.done        = done_q;
  end

  always_ff @(posedge clk) begin
    if (state_q == S_LOAD && bus.in_valid) begin
      buf_mem[ld_beat_q][ld_word_q] <= bus.in_data;
    end
  end

  always_comb begin
    beat_sum = '0;
    prod_a   = '0;
    prod_b   = '0;
    for (int unsigned j = 0; j < WPB; j++) begin
      prod_a   = $signed(buf_mem[beat_q][WORD_W'(j)]);
      prod_b   = $signed(bus.mem_rd_data[32*j +: 32]);
      beat_sum = beat_sum + prod_a * prod_b;
    end
  end

  always_comb begin
    rounded = acc_q + RND_HALF;
    shifted = rounded >>> 16;
    if (shifted > SAT_MAX) begin
      result = 32'h7FFF_FFFF;
    end else if (shifted < SAT_MIN) begin
      result = 32'h8000_0000;
    end else begin
      result = shifted[31:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ld_beat_q   <= '0;
      ld_word_q   <= '0;
      beat_q      <= '0;
      sel_q       <= '0;
      head_q      <= '0;
      dim_q       <= '0;
      acc_q       <= '0;
      next_addr_q <= '0;
      held_addr_q <= '0;
      token_q     <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            token_q     <= bus.token_id;
            next_addr_q <= bus.weight_base_addr;
            ld_beat_q   <= '0;
            ld_word_q   <= '0;
            beat_q      <= '0;
            sel_q       <= '0;
            head_q      <= '0;
            dim_q       <= '0;
            acc_q       <= '0;
          end
        end
        S_LOAD: begin
          if (bus.in_valid) begin
            if (ld_word_q == WORD_W'(WPB - 1)) begin
              ld_word_q <= '0;
              ld_beat_q <= ld_beat_q + 1'b1;
            end else begin
              ld_word_q <= ld_word_q + 1'b1;
            end
          end
        end
        S_REQ: begin
          held_addr_q <= next_addr_q;
        end
        S_WAIT: begin
          // Rows are stored back to back, so the beat address simply advances linearly
          if (bus.mem_rd_valid) begin
            acc_q       <= acc_q + beat_sum;
            next_addr_q <= next_addr_q + BEAT_BYTES;
            beat_q      <= beat_last ? '0 : beat_q + 1'b1;
          end
        end
        S_EMIT: begin
          if (bus.out_ready) begin
            acc_q <= '0;
            if (row_last) begin
              done_q <= 1'b1;
            end
            if (dim_last) begin
              dim_q <= '0;
              if (head_last) begin
                head_q <= '0;
                sel_q  <= sel_q + 2'd1;
              end else begin
                head_q <= head_q + 1'b1;
              end
            end else begin
              dim_q <= dim_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_qkv_projection_engine.sv
// Bench for qkv_projection_engine: a row-by-row dot-product model feeds an expected-result
// queue; a memory responder and an output monitor check the DUT on every relevant cycle.
module tb_qkv_projection_engine;
  localparam int ED     = 32;
  localparam int NH     = 2;
  localparam int HD     = 16;
  localparam int MT     = 128;
  localparam int BW     = 512;
  localparam int WPB    = BW / 32;
  localparam int ROWS   = 3 * ED;
  localparam int HEAD_W = 1;
  localparam int DIM_W  = 4;
  localparam int TOK_W  = 7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  qkv_projection_engine_if #(.NUM_HEADS(NH), .HEAD_DIM(HD), .MAX_TOKENS(MT), .BUS_WIDTH(BW)) bus ();

  qkv_projection_engine #(
    .EMBEDDING_DIM(ED), .NUM_HEADS(NH), .HEAD_DIM(HD), .MAX_TOKENS(MT), .BUS_WIDTH(BW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct packed {
    logic [31:0]       data;
    logic [1:0]        sel;
    logic [HEAD_W-1:0] head;
    logic [DIM_W-1:0]  dim;
    logic [TOK_W-1:0]  tok;
  } res_t;

  int errors = 0;
  int checks = 0;

  logic signed [31:0] xv [ED];
  logic signed [31:0] wm [ROWS][ED];
  res_t        exp_q[$];
  logic [31:0] got_data [ROWS];
  int          got_cnt = 0;
  int          done_cnt = 0;
  int          req_idx = 0;
  logic [31:0] cur_base = '0;
  int          delay_mode = 0;
  bit          stray_req = 0;
  int          stall_at = -1;
  int          stall_left = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_row(input int r);
    longint acc;
    acc = 0;
    for (int i = 0; i < ED; i++) acc += longint'(xv[i]) * longint'(wm[r][i]);
    acc = (acc + 64'sd32768) >>> 16;
    if (acc > 64'sd2147483647) return 32'h7FFF_FFFF;
    if (acc < -64'sd2147483648) return 32'h8000_0000;
    return acc[31:0];
  endfunction

  // Memory responder: one beat per request, answered after a configurable delay
  bit          pend = 0;
  int          pend_cnt = 0;
  logic [BW-1:0] pend_data;
  always @(negedge clk) begin
    int row;
    int bt;
    bus.mem_rd_valid = 1'b0;
    if (bus.mem_rd_en) chk("one_outstanding", 64'(pend), 64'd0);
    if (stray_req) begin
      bus.mem_rd_valid = 1'b1;
      bus.mem_rd_data  = {WPB{32'hBADC_0DE0}};
      stray_req = 0;
    end else if (pend) begin
      if (pend_cnt == 0) begin
        bus.mem_rd_valid = 1'b1;
        bus.mem_rd_data  = pend_data;
        pend = 0;
      end else begin
        pend_cnt--;
      end
    end
    if (bus.mem_rd_en) begin
      chk("rd_addr", 64'(bus.mem_rd_addr), 64'(cur_base + 32'(req_idx * 64)));
      row = req_idx / 2;
      bt  = req_idx % 2;
      for (int j = 0; j < WPB; j++)
        pend_data[32*j +: 32] = (row < ROWS) ? wm[row][bt*WPB + j] : 32'h0;
      pend     = 1;
      pend_cnt = (delay_mode == 1) ? int'($urandom_range(0, 7)) : ((delay_mode == 2) ? 7 : 0);
      req_idx++;
    end
  end

  // Output monitor: drives out_ready, checks stalls, compares accepted results to the model
  bit          held = 0;
  logic [45:0] held_vec;
  always @(negedge clk) begin
    res_t e;
    bus.out_ready = 1'b1;
    if (bus.out_valid && got_cnt == stall_at && stall_left > 0) begin
      bus.out_ready = 1'b0;
      stall_left--;
    end
    if (held) begin
      chk("stall_valid", 64'(bus.out_valid), 64'd1);
      chk("stall_outputs", 64'({bus.out_token, bus.out_sel, bus.out_head, bus.out_dim, bus.out_data}),
          64'(held_vec));
    end
    if (bus.out_valid) chk("no_req_in_emit", 64'(bus.mem_rd_en), 64'd0);
    held = 0;
    if (bus.out_valid && !bus.out_ready) begin
      held     = 1;
      held_vec = {bus.out_token, bus.out_sel, bus.out_head, bus.out_dim, bus.out_data};
    end
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("out_data",  64'(bus.out_data),  64'(e.data));
        chk("out_sel",   64'(bus.out_sel),   64'(e.sel));
        chk("out_head",  64'(bus.out_head),  64'(e.head));
        chk("out_dim",   64'(bus.out_dim),   64'(e.dim));
        chk("out_token", 64'(bus.out_token), 64'(e.tok));
      end
      if (got_cnt < ROWS) got_data[got_cnt] = bus.out_data;
      got_cnt++;
    end
    if (bus.done) begin
      done_cnt++;
      chk("done_after_last", 64'(got_cnt), 64'(ROWS));
    end
  end

  task automatic set_identity();
    for (int i = 0; i < ED; i++) xv[i] = 32'(i) << 16;
    for (int r = 0; r < ROWS; r++)
      for (int i = 0; i < ED; i++) wm[r][i] = (i == r % ED) ? 32'h0001_0000 : 32'h0;
  endtask

  task automatic run_token(input logic [TOK_W-1:0] tok, input logic [31:0] base,
                           input bit abort, input bit disturb);
    res_t e;
    int   k;
    int   cyc;
    bit   acc;
    exp_q.delete();
    for (int r = 0; r < ROWS; r++) begin
      e.data = model_row(r);
      e.sel  = 2'(r / ED);
      e.head = HEAD_W'((r % ED) / HD);
      e.dim  = DIM_W'(r % HD);
      e.tok  = tok;
      exp_q.push_back(e);
    end
    got_cnt = 0; done_cnt = 0; req_idx = 0; cur_base = base;
    @(negedge clk);
    bus.start = 1'b1; bus.token_id = tok; bus.weight_base_addr = base;
    @(negedge clk);
    bus.start = 1'b0; bus.token_id = ~tok; bus.weight_base_addr = 32'hDEAD_BEEF;
    k = 0; cyc = 0;
    while (k < ED && cyc < 500) begin
      bus.in_valid = (cyc % 5 != 3);
      bus.in_data  = xv[k];
      acc = bus.in_valid && bus.in_ready;
      @(negedge clk);
      if (acc) k++;
      cyc++;
    end
    bus.in_valid = 1'b0;
    chk("load_words", 64'(k), 64'(ED));
    if (abort) begin
      cyc = 0;
      while (req_idx < 3 && cyc < 1000) begin @(negedge clk); cyc++; end
      chk("abort_reached_wait", 64'(req_idx >= 3), 64'd1);
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_in_ready",  64'(bus.in_ready),  64'd0);
      chk("rst_mem_rd_en", 64'(bus.mem_rd_en), 64'd0);
      chk("rst_done",      64'(bus.done),      64'd0);
      rst_n = 1'b1;
      exp_q.delete();
      repeat (12) begin
        @(negedge clk);
        chk("post_rst_idle", 64'({bus.out_valid, bus.mem_rd_en, bus.in_ready}), 64'd0);
      end
      chk("stale_consumed", 64'(pend), 64'd0);
      return;
    end
    cyc = 0;
    while (done_cnt == 0 && cyc < 6000) begin
      @(negedge clk);
      cyc++;
      if (disturb) begin
        if (cyc == 30) begin
          bus.start = 1'b1; bus.token_id = 7'h55; bus.weight_base_addr = 32'hDEAD_0000;
        end
        if (cyc == 31) bus.start = 1'b0;
        if (cyc >= 40 && cyc < 46) begin bus.in_valid = 1'b1; bus.in_data = 32'h1234_5678; end
        if (cyc == 46) bus.in_valid = 1'b0;
      end
    end
    chk("done_seen", 64'(done_cnt > 0), 64'd1);
    repeat (4) @(negedge clk);
    chk("done_pulses", 64'(done_cnt), 64'd1);
    chk("result_count", 64'(got_cnt), 64'(ROWS));
    chk("exp_queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    bus.start = 1'b0; bus.token_id = '0; bus.weight_base_addr = '0;
    bus.in_valid = 1'b0; bus.in_data = '0;
    bus.mem_rd_valid = 1'b0; bus.mem_rd_data = '0;
    bus.out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_in_ready",  64'(bus.in_ready),    64'd0);
    chk("reset_mem_rd_en", 64'(bus.mem_rd_en),   64'd0);
    chk("reset_out_valid", 64'(bus.out_valid),   64'd0);
    chk("reset_done",      64'(bus.done),        64'd0);
    chk("reset_addr",      64'(bus.mem_rd_addr), 64'd0);
    chk("reset_out_data",  64'(bus.out_data),    64'd0);
    rst_n = 1'b1;

    // Identity with a stray read beat in IDLE and a mid-token start / in_valid
    set_identity();
    stray_req = 1;
    repeat (2) @(negedge clk);
    run_token(7'd5, 32'h0, 0, 1);
    chk("ident_row0",  64'(got_data[0]),  64'h0);
    chk("ident_row37", 64'(got_data[37]), 64'h0005_0000);
    chk("ident_row95", 64'(got_data[95]), 64'h001F_0000);

    // Positive saturation
    for (int i = 0; i < ED; i++) xv[i] = 32'h7FFF_0000;
    for (int r = 0; r < ROWS; r++) for (int i = 0; i < ED; i++) wm[r][i] = 32'h0001_0000;
    run_token(7'd9, 32'h2000, 0, 0);
    chk("sat_row50", 64'(got_data[50]), 64'h7FFF_FFFF);

    // Rounding and negative results
    for (int i = 0; i < ED; i++) xv[i] = 32'h0;
    for (int r = 0; r < ROWS; r++) for (int i = 0; i < ED; i++) wm[r][i] = 32'h0;
    xv[0] = 32'h0000_8000;
    xv[1] = 32'h8000_0000;
    wm[0][0] = 32'h0000_0001;
    wm[1][0] = 32'hFFFF_FFFF;
    wm[2][0] = 32'hFFFF_FFFD;
    wm[3][1] = 32'h7FFF_FFFF;
    run_token(7'd127, 32'h0, 0, 0);
    chk("round_half_up", 64'(got_data[0]), 64'h0000_0001);
    chk("round_neg_half", 64'(got_data[1]), 64'h0000_0000);
    chk("round_neg_one", 64'(got_data[2]), 64'hFFFF_FFFF);
    chk("sat_negative",  64'(got_data[3]), 64'h8000_0000);

    // Random memory latency plus output backpressure
    set_identity();
    delay_mode = 1;
    stall_at = 40; stall_left = 10;
    run_token(7'd17, 32'h1000, 0, 0);
    chk("stall_row40", 64'(got_data[40]), 64'h0008_0000);
    chk("stall_consumed", 64'(stall_left), 64'd0);
    stall_at = -1;

    // Reset during WAIT with a late beat, then a clean token
    delay_mode = 2;
    run_token(7'd33, 32'h3000, 1, 0);
    delay_mode = 1;
    run_token(7'd3, 32'h1000, 0, 0);
    chk("recover_row63", 64'(got_data[63]), 64'h001F_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
